// File: rtl/debug_send_arbiter.sv
// debug_send_arbiter
//   Round-robin arbiter that shares one 40-bit serial debug sender among
//   NUM_REQ requesters. For each frame it captures the winner's 32-bit
//   payload, prepends an 8-bit tag, strobes the sender, and then follows the
//   sender's state through a full shift-out before it grants again.
//
//   Frame layout: data[39:8] = payload, data[7:4] = sequence, data[3:0] = index.
//   The sender shifts LSB first, so the tag leaves first.
//
//   Optional feature: define DEBUG_SEND_ARB_SEQ_EN to build the 4-bit frame
//   sequence counter that fills tag[7:4]. Without it, tag[7:4] is 4'b0000.
//
// Ports
//   in_clk        block clock, rising edge
//   reset         synchronous, active-high
//   req           per-requester request, held with payload until ack
//   payload       flat payloads, requester i on [32*i+31:32*i]
//   ack           one-cycle pulse to the requester whose payload was captured
//   store         one-cycle load strobe to the sender
//   data          frame to the sender, stable between captures
//   sender_state  sender busy flag, asynchronous to in_clk
//   busy          high whenever the FSM is not idle
//   timeout_err   sticky flag, set when the sender fails to start in time
module debug_send_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    in_clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   payload,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    store,
  output logic [39:0]             data,
  input  logic                    sender_state,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
  localparam logic [7:0] GUARD_LAST   = 8'(GUARD_CYCLES - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] STORE   = 3'd1;
  localparam logic [2:0] WAIT_HI = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] GUARD   = 3'd4;

  logic [2:0]         state;
  logic [7:0]         cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic               sync_1;
  logic               state_sync;
  logic [3:0]         seq_field;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [39:0]        next_frame;
  int                 cand;

`ifdef DEBUG_SEND_ARB_SEQ_EN
  logic [3:0] seq;
  assign seq_field = seq;
`else
  assign seq_field = 4'b0000;
`endif

  assign busy = (state != IDLE);

  // Round-robin search: first set request after rr_ptr, wrapping modulo NUM_REQ.
  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
    grant_onehot = NUM_REQ'(1) << grant_idx;
    next_frame   = {payload[32*int'(grant_idx) +: 32], seq_field, 4'(grant_idx)};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      sync_1      <= 1'b0;
      state_sync  <= 1'b0;
      ack         <= '0;
      store       <= 1'b0;
      data        <= '0;
      timeout_err <= 1'b0;
`ifdef DEBUG_SEND_ARB_SEQ_EN
      seq         <= '0;
`endif
    end else begin
      // Two-flop synchroniser for the sender's asynchronous state.
      sync_1     <= sender_state;
      state_sync <= sync_1;

      ack   <= '0;
      store <= 1'b0;

      case (state)
        IDLE: begin
          // Waiting for state_sync=0 keeps a frame the sender latched before
          // a reset from being overwritten by the first post-reset grant.
          if (grant_found && !state_sync) begin
            data   <= next_frame;
            ack    <= grant_onehot;
            rr_ptr <= grant_idx;
            state  <= STORE;
          end
        end
        STORE: begin
          store <= 1'b1;
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (state_sync) begin
            state <= WAIT_LO;
          end else if (cnt == TIMEOUT_LAST) begin
            // Retry the same frame; the requester was already acked.
            timeout_err <= 1'b1;
            state       <= STORE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_LO: begin
          if (!state_sync) begin
`ifdef DEBUG_SEND_ARB_SEQ_EN
            seq <= seq + 4'd1;
`endif
            cnt   <= '0;
            state <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
          end
        end
        GUARD: begin
          if (cnt == GUARD_LAST) state <= IDLE;
          else                   cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_send_arbiter.sv
module tb_debug_send_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 64;
  localparam int GC   = 4;

  typedef struct packed {
    int          idx;
    logic [39:0] data;
  } exp_t;

  logic                 in_clk = 1'b0;
  logic                 reset  = 1'b1;
  logic [NREQ-1:0]      req    = '0;
  logic [NREQ*32-1:0]   payload;
  logic [NREQ-1:0]      ack;
  logic                 store;
  logic [39:0]          data;
  logic                 sender_state = 1'b0;
  logic                 busy;
  logic                 timeout_err;

  logic [31:0]     pay [NREQ];
  logic [NREQ-1:0] hold = '0;
  logic            sender_mute = 1'b0;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acks_seen = 0;

  // Reference model state: last granted requester and next sequence value.
  int         last_m = NREQ - 1;
  logic [3:0] seq_m  = 4'd0;

  logic        pend_store = 1'b0;
  logic [39:0] pend_data  = '0;

  always_comb payload = {pay[3], pay[2], pay[1], pay[0]};

  always #5 in_clk = ~in_clk;

  debug_send_arbiter #(
    .NUM_REQ(NREQ), .BUSY_TIMEOUT(TO), .GUARD_CYCLES(GC)
  ) dut (
    .in_clk(in_clk), .reset(reset), .req(req), .payload(payload),
    .ack(ack), .store(store), .data(data), .sender_state(sender_state),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push the expected frame for a grant to requester idx.
  task automatic expect_grant(input int idx);
    exp_t e;
    logic [3:0] tag_hi;
`ifdef DEBUG_SEND_ARB_SEQ_EN
    tag_hi = seq_m;
`else
    tag_hi = 4'h0;
`endif
    e.idx  = idx;
    e.data = {pay[idx], tag_hi, 4'(idx)};
    sb.push_back(e);
    seq_m  = seq_m + 4'd1;
    last_m = idx;
  endtask

  // Requests all pending at once are served in cyclic order after the last grant.
  task automatic model_order(input logic [NREQ-1:0] mask);
    int start;
    start = last_m;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (mask[i]) expect_grant(i);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req   = '0;
    hold  = '0;
    step();
    step();
    reset  = 1'b0;
    last_m = NREQ - 1;
    seq_m  = 4'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge in_clk);
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_acks(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (acks_seen < target && n < budget) begin
      @(negedge in_clk);
      n++;
    end
    check(name, 64'(acks_seen), 64'(target));
  endtask

  // Sender model: starts shifting a few cycles after store, busy for 40 cycles.
  initial begin
    forever begin
      @(negedge in_clk);
      if (store === 1'b1 && !sender_mute) begin
        repeat ($urandom_range(1, 6)) @(posedge in_clk);
        #1 sender_state = 1'b1;
        repeat (40) @(posedge in_clk);
        #1 sender_state = 1'b0;
      end
    end
  end

  // Monitor: compares every ack and the following store/data with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge in_clk);
      if (pend_store) begin
        check("store_after_ack", 64'(store), 64'd1);
        check("frame_data", 64'(data), 64'(pend_data));
        pend_store = 1'b0;
      end
      if (ack !== '0) begin
        acks_seen++;
        if (sb.size() == 0) begin
          check("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          e = sb.pop_front();
          check("ack_onehot", 64'(ack), 64'(1) << e.idx);
          pend_store = 1'b1;
          pend_data  = e.data;
        end
        req = req & ~(ack & ~hold);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, t[3], ns;
    logic [39:0] exp_d;
    logic early;
    logic [NREQ-1:0] mask;

    for (int i = 0; i < NREQ; i++) pay[i] = '0;

    // Reset values.
    repeat (3) @(posedge in_clk);
    #1 reset = 1'b0;
    @(negedge in_clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_store", 64'(store), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);

    // Single request from requester 1.
    step();
    pay[1] = 32'hDEADBEEF;
    req    = 4'b0010;
    model_order(4'b0010);
    check("single_exp_model", 64'(sb[0].data), 64'h00DEADBEEF01);
    wait_acks("single_ack", 1, 20);
    check("single_busy_at_ack", 64'(busy), 64'd1);
    n = 0;
    while (sender_state !== 1'b1 && n < 100) begin @(negedge in_clk); n++; end
    n = 0;
    while (sender_state !== 1'b0 && n < 100) begin @(negedge in_clk); n++; end
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; @(negedge in_clk); end
    check("single_busy_tail", 64'(n), 64'(3 + GC));
    wait_done("single_done", 200);

    // Request that drops before being granted sends no frame.
    base = acks_seen;
    step();
    pay[0] = $urandom;
    req[0] = 1'b1;
    model_order(4'b0001);
    wait_acks("drop_first_ack", base + 1, 20);
    step();
    req[3] = 1'b1;
    repeat (5) step();
    req[3] = 1'b0;
    wait_done("drop_done", 300);
    repeat (10) @(negedge in_clk);
    check("drop_no_frame", 64'(acks_seen), 64'(base + 1));

    // Round robin with all requests held.
    do_reset();
    base = acks_seen;
    for (int i = 0; i < NREQ; i++) pay[i] = $urandom;
    hold = 4'b1111;
    req  = 4'b1111;
    for (int f = 0; f < 5; f++) expect_grant(f % NREQ);
    wait_acks("rr_acks", base + 5, 600);
    hold = '0;
    req  = '0;
    wait_done("rr_done", 300);

    // Randomised request batches.
    for (int b = 0; b < 8; b++) begin
      step();
      mask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) pay[i] = $urandom;
      req = mask;
      model_order(mask);
      wait_done("batch_done", 600);
    end

    // Sequence wrap: 17 frames from requester 2.
    for (int f = 0; f < 17; f++) begin
      step();
      pay[2] = $urandom;
      req[2] = 1'b1;
      model_order(4'b0100);
      wait_done("seq_done", 300);
    end

    // Fairness with a late arrival.
    do_reset();
    base = acks_seen;
    pay[0] = $urandom;
    pay[3] = $urandom;
    hold   = 4'b0001;
    req[0] = 1'b1;
    expect_grant(0);
    wait_acks("fair_first", base + 1, 20);
    step();
    req[3] = 1'b1;
    expect_grant(3);
    expect_grant(0);
    wait_acks("fair_rest", base + 3, 400);
    hold   = '0;
    req[0] = 1'b0;
    wait_done("fair_done", 300);

    // Reset in the middle of a frame while the sender is still shifting.
    base = acks_seen;
    step();
    pay[1] = $urandom;
    req[1] = 1'b1;
    model_order(4'b0010);
    wait_acks("mid_ack", base + 1, 20);
    n = 0;
    while (sender_state !== 1'b1 && n < 50) begin @(negedge in_clk); n++; end
    repeat (6) @(posedge in_clk);
    #1 reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge in_clk);
    check("mid_rst_ack", 64'(ack), 64'd0);
    check("mid_rst_store", 64'(store), 64'd0);
    check("mid_rst_data", 64'(data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    last_m = NREQ - 1;
    seq_m  = 4'd0;
    repeat (3) step();
    pay[2] = $urandom;
    req[2] = 1'b1;
    model_order(4'b0100);
    early = 1'b0;
    n = 0;
    while (sender_state === 1'b1 && n < 100) begin
      @(negedge in_clk);
      if (ack !== '0 && sender_state === 1'b1) early = 1'b1;
      n++;
    end
    check("mid_no_early_ack", 64'(early), 64'd0);
    wait_acks("mid_post_ack", base + 2, 20);
    wait_done("mid_done", 300);

    // Timeout and retry with a silent sender.
    do_reset();
    base = acks_seen;
    sender_mute = 1'b1;
    step();
    pay[1] = $urandom;
    req[1] = 1'b1;
    model_order(4'b0010);
    exp_d = sb[0].data;
    ns = 0;
    n  = 0;
    while (ns < 3 && n < 300) begin
      @(negedge in_clk);
      n++;
      if (store === 1'b1) begin
        t[ns] = n;
        check("to_data_stable", 64'(data), 64'(exp_d));
        if (ns == 0) check("to_err_before", 64'(timeout_err), 64'd0);
        if (ns == 1) check("to_err_after", 64'(timeout_err), 64'd1);
        ns++;
      end
    end
    check("to_store_count", 64'(ns), 64'd3);
    check("to_period_1", 64'(t[1] - t[0]), 64'(TO + 1));
    check("to_period_2", 64'(t[2] - t[1]), 64'(TO + 1));
    check("to_single_ack", 64'(acks_seen), 64'(base + 1));
    sender_mute = 1'b0;
    wait_done("to_done", 400);
    check("to_err_sticky", 64'(timeout_err), 64'd1);
    check("to_single_ack_end", 64'(acks_seen), 64'(base + 1));
    do_reset();
    @(negedge in_clk);
    check("to_err_cleared", 64'(timeout_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_send_arbiter.md
Name: debug_send_arbiter

Overview:
- Shares the single 40-bit serial debug sender among NUM_REQ requesters in the in_clk domain, using round-robin arbitration.
- Per frame: captures the winner's 32-bit payload, prepends an 8-bit tag, pulses store to the sender, then follows the sender's state through a full shift-out before granting again.
- Sits between debug probes and the serial sender; drives the sender's store/data and reads its state output.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- BUSY_TIMEOUT, 64, in_clk cycles allowed for synced sender state to rise after store; range 2..255.
- GUARD_CYCLES, 4, idle in_clk cycles after the sender returns empty, before the next grant; range 0..15.

Ports:
- in_clk  input  1  block clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- req  input  NUM_REQ  per-requester request; held high with payload stable until ack.
- payload  input  NUM_REQ*32  flat payloads; requester i uses bits [32*i+31:32*i].
- ack  output  NUM_REQ  one-cycle pulse to the granted requester when its payload is captured.
- store  output  1  one-cycle load strobe to the sender.
- data  output  40  frame to the sender; stable from capture until the next capture.
- sender_state  input  1  sender state, asynchronous to in_clk; synchronised internally by two flops.
- busy  output  1  high whenever the FSM is not IDLE.
- timeout_err  output  1  sticky; set on any BUSY_TIMEOUT expiry; cleared only by reset.

Behaviour:
- Reset values: ack=0, store=0, data=0, busy=0, timeout_err=0, rr_ptr=NUM_REQ-1, seq=0, FSM=IDLE, sync flops=0.
- Frame format:
  - data[7:0] = tag, data[39:8] = payload.
  - tag[3:0] = winner index; tag[7:4] = seq (see optional feature).
  - Sender shifts LSB first, so the tag leaves first.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Same cycle: data is registered, ack[winner] pulses, rr_ptr is set to the winner, FSM goes to STORE.
  - Capture-to-store latency is 1 cycle.
- STORE: store=1 for exactly one cycle; timeout counter cleared; go to WAIT_HI.
- WAIT_HI:
  - Synced state=1 → WAIT_LO.
  - Counter reaches BUSY_TIMEOUT-1 → timeout_err set, store re-pulsed via STORE with the same data (retry; no new ack).
- WAIT_LO: synced state=0 → GUARD; no timeout in this state.
- GUARD: counts GUARD_CYCLES cycles, then IDLE; GUARD_CYCLES=0 goes straight to IDLE.
- Each completed frame (WAIT_LO→GUARD) increments seq, wrapping 15→0.
- Boundary conditions:
  - req deasserted after ack: ignored.
  - req deasserted before grant: no frame sent.
  - All req set continuously: grants rotate 0,1,2,3,0,… with no requester starving.
  - Single requester repeatedly: granted every frame.
  - reset mid-frame: FSM returns to IDLE next edge; a frame already latched by the sender still shifts out; the first post-reset grant waits in IDLE until synced state=0.
  - Requests arriving during a frame are held; no queueing beyond the req level.

Optional Feature:
- Macro DEBUG_SEND_ARB_SEQ_EN.
- Defined: tag[7:4] = 4-bit frame sequence counter as above.
- Undefined: tag[7:4] = 4'b0000 and the seq register is not built.

Test Plan:
- Single request: reset, req=4'b0010, payload1=32'hDEADBEEF → ack[1] pulses once; store one cycle later; data=40'hDEADBEEF01 (seq 0); busy high until the sender model returns state=0 plus 4 guard cycles.
- Round-robin: req=4'b1111 held, sender model responds normally → tags in order 0x00,0x11,0x22,0x33,0x40 (seq enabled); each ack exactly once per frame.
- Timeout and retry: sender model never raises state → store re-pulses every 65 cycles (1 STORE + 64 WAIT_HI); timeout_err goes 1 and stays; data unchanged; no second ack.
- Sequence wrap: 17 frames from requester 2 → tag[7:4] runs 0..15 then 0; with DEBUG_SEND_ARB_SEQ_EN undefined, every tag = 8'h02.
- Reset mid-frame: assert reset during WAIT_LO with sender state=1 → outputs return to reset values; a new req is not acked until synced state=0.
- Fairness with late arrival: req0 held continuously, req3 raised during frame 0 → next grant goes to 3, then 0.
